arcadia_cart_loader: RTL and testbench
======================================

ARCADIA_CART_LOADER -- requirements
Module: arcadia_cart_loader

Interface
REQ-001 SHALL have parameter CART_INDEX, default 8'd1: the ioctl_index value that selects a cartridge image.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: number of byte entries in the internal buffer.
REQ-003 clk  in  1  system clock; all logic in this single domain.
REQ-004 reset_n  in  1  synchronous, active-low reset.
REQ-005 ioctl_download  in  1  high while the HPS transfer is active.
REQ-006 ioctl_index  in  8  file index of the transfer.
REQ-007 ioctl_wr  in  1  one-cycle strobe: byte valid.
REQ-008 ioctl_addr  in  25  byte address of ioctl_dout.
REQ-009 ioctl_dout  in  8  download byte.
REQ-010 ioctl_wait  out  1  registered backpressure to the HPS.
REQ-011 mem_addr  out  15  cartridge RAM write address.
REQ-012 mem_data  out  8  cartridge RAM write data.
REQ-013 mem_we  out  1  write valid; held until accepted.
REQ-014 mem_ready  in  1  RAM accepts the write in any cycle where mem_we && mem_ready.
REQ-015 cpu_hold  out  1  holds the console CPU in reset while a load is active.
REQ-016 cart_loaded  out  1  a complete image is present.
REQ-017 cart_size  out  16  number of bytes accepted (1..32768).
REQ-018 size_mask  out  15  address mirror mask for the cartridge decoder.
REQ-019 overflow  out  1  sticky flag: a byte was dropped because its address was at or above 32768.

Function
REQ-020 SHALL implement the states IDLE, LOAD, FLUSH and DONE.
REQ-021 SHALL go from IDLE or DONE to LOAD on the rising edge of ioctl_download when ioctl_index==CART_INDEX, and on that entry SHALL clear cart_size, overflow and cart_loaded.
REQ-022 SHALL ignore a download whose index does not match: no state change, no FIFO push, ioctl_wait stays 0.
REQ-023 In LOAD, an ioctl_wr with ioctl_addr<32768 SHALL push {addr[14:0], dout} into the FIFO.
REQ-024 In LOAD, an ioctl_wr with ioctl_addr>=32768 SHALL drop the byte and set overflow.
REQ-025 On each accepted push, cart_size SHALL become max(cart_size, addr+1).
REQ-026 SHALL go from LOAD to FLUSH on the falling edge of ioctl_download.
REQ-027 SHALL go from FLUSH to DONE when the FIFO is empty and mem_we is low; cart_loaded SHALL be set on entry to DONE.
REQ-028 When the FIFO is non-empty, mem_we SHALL be high with mem_addr and mem_data taken from the FIFO head.
REQ-029 mem_addr and mem_data SHALL stay stable until the cycle mem_we && mem_ready; the FIFO pops in that cycle.
REQ-030 The first byte SHALL reach mem_we no sooner than 1 cycle after its ioctl_wr.
REQ-031 A push and a pop in the same cycle SHALL leave the count unchanged.
REQ-032 ioctl_wait SHALL be registered: high in the cycle after the post-update count is >=FIFO_DEPTH-2, low in the cycle after it is <FIFO_DEPTH-2.
REQ-033 The margin in REQ-032 SHALL absorb one write arriving in the cycle wait rises.
REQ-034 A push while full SHALL be discarded and SHALL set overflow.
REQ-035 cpu_hold SHALL equal (state==LOAD || state==FLUSH).
REQ-036 size_mask SHALL be the smallest 2^n-1 that is >= cart_size-1, clamped to the range 0x07FF..0x7FFF.
REQ-037 size_mask SHALL be updated combinationally from cart_size.

Reset
REQ-038 While reset_n is low at a clk edge: state=IDLE, FIFO empty, ioctl_wait=0, mem_we=0, cpu_hold=0, cart_loaded=0, cart_size=0, overflow=0.
REQ-039 mem_addr and mem_data SHALL reset to 0.
REQ-040 Reset asserted mid-LOAD or mid-FLUSH SHALL abandon pending bytes.
REQ-041 After reset, a new load SHALL start only on a fresh rising edge of ioctl_download.

Structure
REQ-042 The state enum, CART_MAX_BYTES=32768 and MIN_MASK=15'h07FF SHALL live in package arcadia_pkg.
REQ-043 The FIFO SHALL be one sub-module, arcadia_byte_fifo (parameter depth, width 23), with push/pop/count/full/empty ports.

Verification
REQ-044 Index 1 download of 4096 bytes, mem_ready=1 -> 4096 writes in address order; cart_size=4096; size_mask=0x0FFF; cart_loaded=1; overflow=0.
REQ-045 mem_ready=0 for 20 cycles mid-load, ioctl_wr every cycle -> ioctl_wait high within 2 cycles, no byte lost, FIFO never above 4.
REQ-046 Index 2 download of 16 bytes -> no mem_we, cpu_hold=0, ioctl_wait=0, cart_loaded unchanged.
REQ-047 Bytes at 0x7FFF and 0x8000 -> 0x7FFF written; 0x8000 dropped; overflow=1; cart_size=32768; size_mask=0x7FFF.
REQ-048 1000-byte load -> size_mask=0x07FF (clamp).
REQ-049 reset_n low for 1 cycle during FLUSH with 3 bytes queued -> next cycle all outputs at reset values and no further mem_we.

Source files
------------

// File: rtl/arcadia_pkg.sv
// Shared types and constants for the Arcadia cartridge loader.
// Holds the loader state enum, image limits and the mirror-mask helper.
package arcadia_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FLUSH,
        DONE
    } state_t;

    localparam int          CART_MAX_BYTES = 32768;
    localparam logic [14:0] MIN_MASK       = 15'h07FF;

    // Smallest 2^n-1 covering the highest address (size-1), clamped to
    // the 2 KiB .. 32 KiB window the cartridge decoder supports.
    function automatic logic [14:0] mask_for_size(input logic [15:0] size);
        logic [15:0] v;
        v = size - 16'd1;
        v = v | (v >> 1);
        v = v | (v >> 2);
        v = v | (v >> 4);
        v = v | (v >> 8);
        if (size == 16'd0)
            return MIN_MASK;
        if (v[15])
            return 15'h7FFF;
        if (v[14:0] < MIN_MASK)
            return MIN_MASK;
        return v[14:0];
    endfunction

endpackage

// File: rtl/arcadia_byte_fifo.sv
// Small synchronous FIFO holding {addr, byte} entries between the HPS
// download port and cartridge RAM.
// Ports: clk, reset_n (sync, active low), push/push_data, pop/pop_data
// (head, valid when !empty), count, full, empty.
module arcadia_byte_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 23
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [WIDTH-1:0] store [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == LAST) ? '0 : p + AW'(1);
    endfunction

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = store[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= nxt(wr_ptr);
            if (do_pop)
                rd_ptr <= nxt(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: the head is only used while non-empty.
    always_ff @(posedge clk) begin
        if (do_push)
            store[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/arcadia_cart_loader.sv
// Streams an HPS cartridge download into cartridge RAM through a small
// buffer, holding the console CPU while the image is being written.
// Ports: ioctl_* download port in, ioctl_wait backpressure out;
// mem_addr/mem_data/mem_we/mem_ready RAM write port; cpu_hold,
// cart_loaded, cart_size, size_mask, overflow status out.
module arcadia_cart_loader
    import arcadia_pkg::*;
#(
    parameter logic [7:0] CART_INDEX = 8'd1,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic [14:0] mem_addr,
    output logic [7:0]  mem_data,
    output logic        mem_we,
    input  logic        mem_ready,
    output logic        cpu_hold,
    output logic        cart_loaded,
    output logic [15:0] cart_size,
    output logic [14:0] size_mask,
    output logic        overflow
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    // Two-entry margin: one write can still land in the cycle wait rises.
    localparam logic [CW-1:0] WAIT_LVL = CW'(FIFO_DEPTH - 2);

    state_t        state_q;
    state_t        state_d;
    logic          dl_q;
    logic          dl_rise;
    logic          dl_fall;
    logic          wr_ok;
    logic          in_range;
    logic          push;
    logic          push_ok;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] count_d;
    logic [22:0]   head;
    logic [15:0]   addr_plus;
    logic          enter_load;
    logic          enter_done;

    assign dl_rise   = ioctl_download & ~dl_q;
    assign dl_fall   = ~ioctl_download & dl_q;
    assign in_range  = (ioctl_addr[24:15] == '0);
    assign wr_ok     = (state_q == LOAD) & ioctl_wr;
    assign push      = wr_ok & in_range;
    assign push_ok   = push & ~fifo_full;
    assign mem_we    = ~fifo_empty;
    assign pop       = mem_we & mem_ready;
    assign count_d   = fifo_count + CW'(push_ok) - CW'(pop);
    assign addr_plus = {1'b0, ioctl_addr[14:0]} + 16'd1;
    assign cpu_hold  = (state_q == LOAD) | (state_q == FLUSH);
    assign size_mask = mask_for_size(cart_size);

    // Idle RAM port presents zeros rather than stale buffer contents.
    assign {mem_addr, mem_data} = fifo_empty ? 23'd0 : head;

    arcadia_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (23)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data ({ioctl_addr[14:0], ioctl_dout}),
        .pop       (pop),
        .pop_data  (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        enter_load = 1'b0;
        enter_done = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (dl_rise && ioctl_index == CART_INDEX) begin
                    state_d    = LOAD;
                    enter_load = 1'b1;
                end
            end
            LOAD: begin
                if (dl_fall)
                    state_d = FLUSH;
            end
            FLUSH: begin
                if (fifo_empty && !mem_we) begin
                    state_d    = DONE;
                    enter_done = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            // Treat download as already high so a transfer that spans
            // reset is not mistaken for a fresh start.
            dl_q        <= 1'b1;
            ioctl_wait  <= 1'b0;
            cart_loaded <= 1'b0;
            cart_size   <= '0;
            overflow    <= 1'b0;
        end else begin
            state_q    <= state_d;
            dl_q       <= ioctl_download;
            ioctl_wait <= (count_d >= WAIT_LVL);
            if (enter_load) begin
                cart_size   <= '0;
                overflow    <= 1'b0;
                cart_loaded <= 1'b0;
            end else begin
                if (push_ok && addr_plus > cart_size)
                    cart_size <= addr_plus;
                if (wr_ok && (!in_range || fifo_full))
                    overflow <= 1'b1;
                if (enter_done)
                    cart_loaded <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_arcadia_cart_loader.sv
// Directed bench for arcadia_cart_loader with a write scoreboard.
// Expected RAM writes are queued by the stimulus and popped by a monitor.
module tb_arcadia_cart_loader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = 8'd1;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic        ioctl_wait;
    logic [14:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_we;
    logic        mem_ready = 1'b1;
    logic        cpu_hold;
    logic        cart_loaded;
    logic [15:0] cart_size;
    logic [14:0] size_mask;
    logic        overflow;

    int n_tests = 0;
    int n_fail = 0;
    int n_writes = 0;
    int max_cnt = 0;
    logic [22:0] exp_q[$];

    arcadia_cart_loader #(
        .CART_INDEX (8'd1),
        .FIFO_DEPTH (4)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .mem_we         (mem_we),
        .mem_ready      (mem_ready),
        .cpu_hold       (cpu_hold),
        .cart_loaded    (cart_loaded),
        .cart_size      (cart_size),
        .size_mask      (size_mask),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: bound expired", name);
    endtask

    function automatic logic [7:0] pat(input logic [24:0] a);
        logic [7:0] r;
        r = a[7:0] * 8'd13;
        r = r + a[15:8] + 8'd7;
        return r;
    endfunction

    // Monitor: every accepted RAM write must match the queue head.
    always @(negedge clk) begin
        logic [22:0] e;
        if (reset_n && mem_we && mem_ready) begin
            n_writes++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected",
                         mem_addr, mem_data);
            end else begin
                e = exp_q.pop_front();
                check("mem_write", {9'd0, mem_addr, mem_data}, {9'd0, e});
            end
        end
        if (int'(dut.u_fifo.count) > max_cnt)
            max_cnt = int'(dut.u_fifo.count);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_wr(input logic [24:0] a, input bit exp_it);
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_dout = pat(a);
        if (exp_it)
            exp_q.push_back({a[14:0], pat(a)});
        tick();
        ioctl_wr = 1'b0;
    endtask

    task automatic wr_byte(input logic [24:0] a, input bit exp_it);
        int budget = 200;
        while (ioctl_wait && budget > 0) begin
            tick();
            budget--;
        end
        if (ioctl_wait)
            fail_now("wait_timeout");
        drive_wr(a, exp_it);
    endtask

    task automatic start_dl(input logic [7:0] idx);
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        tick();
    endtask

    task automatic end_dl;
        int budget = 20000;
        ioctl_download = 1'b0;
        tick();
        while (cpu_hold && budget > 0) begin
            tick();
            budget--;
        end
        if (cpu_hold)
            fail_now("flush_timeout");
        tick();
        tick();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int rise_at;
        int a;

        // Reset values
        tick();
        tick();
        check("rst_wait", ioctl_wait, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_cpu_hold", cpu_hold, 0);
        check("rst_loaded", cart_loaded, 0);
        check("rst_size", cart_size, 0);
        check("rst_overflow", overflow, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_data", mem_data, 0);
        check("rst_mask", size_mask, 15'h07FF);
        reset_n = 1'b1;
        tick();

        // 4096-byte image, RAM always ready
        base = n_writes;
        start_dl(8'd1);
        check("a_cpu_hold", cpu_hold, 1);
        for (int i = 0; i < 4096; i++)
            wr_byte(25'(i), 1'b1);
        end_dl();
        check("a_writes", n_writes - base, 4096);
        check("a_queue", exp_q.size(), 0);
        check("a_size", cart_size, 4096);
        check("a_mask", size_mask, 15'h0FFF);
        check("a_loaded", cart_loaded, 1);
        check("a_overflow", overflow, 0);
        check("a_cpu_hold_end", cpu_hold, 0);

        // RAM stalls for 20 cycles while the HPS writes every cycle
        base = n_writes;
        start_dl(8'd1);
        check("b_loaded_cleared", cart_loaded, 0);
        for (int i = 0; i < 10; i++)
            wr_byte(25'(i), 1'b1);
        a = 10;
        max_cnt = 0;
        rise_at = -1;
        mem_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (!ioctl_wait) begin
                ioctl_wr   = 1'b1;
                ioctl_addr = 25'(a);
                ioctl_dout = pat(25'(a));
                exp_q.push_back({15'(a), pat(25'(a))});
                a++;
            end else begin
                ioctl_wr = 1'b0;
            end
            tick();
            if (ioctl_wait && rise_at < 0)
                rise_at = k + 1;
        end
        ioctl_wr = 1'b0;
        mem_ready = 1'b1;
        while (a < 64) begin
            wr_byte(25'(a), 1'b1);
            a++;
        end
        end_dl();
        check("b_wait_rise_le2", (rise_at >= 1 && rise_at <= 2), 1);
        check("b_fifo_max_le4", (max_cnt <= 4), 1);
        check("b_writes", n_writes - base, 64);
        check("b_queue", exp_q.size(), 0);
        check("b_size", cart_size, 64);
        check("b_overflow", overflow, 0);
        check("b_loaded", cart_loaded, 1);

        // Non-matching index is ignored
        base = n_writes;
        start_dl(8'd2);
        check("c_cpu_hold", cpu_hold, 0);
        for (int i = 0; i < 16; i++)
            wr_byte(25'(i), 1'b0);
        check("c_wait", ioctl_wait, 0);
        check("c_mem_we", mem_we, 0);
        end_dl();
        ioctl_index = 8'd1;
        check("c_writes", n_writes - base, 0);
        check("c_loaded", cart_loaded, 1);
        check("c_size", cart_size, 64);

        // Top of window and first out-of-range address
        base = n_writes;
        start_dl(8'd1);
        wr_byte(25'h0010, 1'b1);
        wr_byte(25'h7FFF, 1'b1);
        wr_byte(25'h8000, 1'b0);
        end_dl();
        check("d_writes", n_writes - base, 2);
        check("d_queue", exp_q.size(), 0);
        check("d_overflow", overflow, 1);
        check("d_size", cart_size, 32768);
        check("d_mask", size_mask, 15'h7FFF);
        check("d_loaded", cart_loaded, 1);

        // 1000-byte image clamps the mask at 2 KiB
        base = n_writes;
        start_dl(8'd1);
        for (int i = 0; i < 1000; i++)
            wr_byte(25'(i), 1'b1);
        end_dl();
        check("e_writes", n_writes - base, 1000);
        check("e_size", cart_size, 1000);
        check("e_mask", size_mask, 15'h07FF);
        check("e_overflow", overflow, 0);

        // Reset while flushing three queued bytes
        mem_ready = 1'b0;
        start_dl(8'd1);
        drive_wr(25'd0, 1'b1);
        drive_wr(25'd1, 1'b1);
        check("f_wait_up", ioctl_wait, 1);
        drive_wr(25'd2, 1'b1);
        check("f_absorbed", overflow, 0);
        ioctl_download = 1'b0;
        tick();
        check("f_flush_hold", cpu_hold, 1);
        check("f_flush_we", mem_we, 1);
        check("f_flush_addr", mem_addr, 0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        exp_q.delete();
        check("f_rst_we", mem_we, 0);
        check("f_rst_addr", mem_addr, 0);
        check("f_rst_data", mem_data, 0);
        check("f_rst_hold", cpu_hold, 0);
        check("f_rst_wait", ioctl_wait, 0);
        check("f_rst_loaded", cart_loaded, 0);
        check("f_rst_size", cart_size, 0);
        check("f_rst_overflow", overflow, 0);
        mem_ready = 1'b1;
        base = n_writes;
        repeat (5) tick();
        check("f_no_writes", n_writes - base, 0);
        check("f_idle_hold", cpu_hold, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
